myalu_core: RTL and testbench

MYALU_CORE -- requirements
Module: myalu

---
 rtl/myalu_core_if.sv | 28 ++
 rtl/myalu_core.sv | 166 ++++++++++++++++
 tb/tb_myalu_core.sv | 107 ++++++++++
 3 files changed

// File: rtl/myalu_core_if.sv
// Operand, strobe and result bundle for myalu_core.
// The master drives operands and one-hot op strobes; the slave (ALU) returns registered results.
interface myalu_core_if;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        ni;
  logic        ci;
  logic        mbyte;
  logic        add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst;
  logic        ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab;
  logic [15:0] final_result;
  logic [3:0]  final_flags;
  logic [3:0]  ccmask;

  modport master (
    output in1, in2, ni, ci, mbyte,
    output add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst,
    output ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab,
    input  final_result, final_flags, ccmask
  );

  modport slave (
    input  in1, in2, ni, ci, mbyte,
    input  add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst,
    input  ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab,
    output final_result, final_flags, ccmask
  );
endinterface

// File: rtl/myalu_core.sv
// PDP-11 style single-cycle ALU: one-hot op strobes in, registered result/{N,Z,V,C}/update mask out.
// Define MYALU_BYTE_EN to enable byte-wide operation of the eligible ops when mbyte is high.
module myalu_core (
  input  logic         clk,
  input  logic         reset,
  myalu_core_if.slave  bus
);
  // Enum order mirrors strobe priority: lower code = higher priority.
  typedef enum logic [4:0] {
    OP_NONE, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC2, OP_DEC2, OP_INC, OP_DEC,
    OP_CLR, OP_COM, OP_NEG, OP_TST, OP_ROR, OP_ROL, OP_ASR, OP_ASL, OP_SXT,
    OP_MOV, OP_CMP, OP_BIT, OP_BIC, OP_BIS, OP_EXOR, OP_SWAB
  } op_e;

  logic [23:0] strb;
  op_e         op;
  logic        byte_m;
  logic [15:0] s, d;
  logic [15:0] ax, ay;
  logic        acin;
  logic [16:0] sum17;
  logic [8:0]  sum9;
  logic [15:0] add_r;
  logic        add_c;
  logic        sd, ss, sa;
  logic        d_maxpos, d_minneg, d_ones, d_zero, r_minneg, r_zero;
  logic        n, z, v, c, shift;
  logic [15:0] result_d, result_q;
  logic [3:0]  flags_d, flags_q, mask_d, mask_q;

  assign s    = bus.in1;
  assign d    = bus.in2;
  assign strb = {bus.swab, bus.exor, bus.bis, bus.bic, bus.bit_, bus.cmp, bus.mov, bus.sxt,
                 bus.asl, bus.asr, bus.rol, bus.ror, bus.tst, bus.neg, bus.com, bus.clr,
                 bus.dec, bus.inc, bus.dec2, bus.inc2, bus.sbc, bus.sub, bus.adc, bus.add};

  always_comb begin
    op = OP_NONE;
    for (int i = 23; i >= 0; i--) begin
      if (strb[i]) op = op_e'(5'(i + 1));
    end
  end

`ifdef MYALU_BYTE_EN
  assign byte_m = bus.mbyte &&
                  !(op inside {OP_ADD, OP_SUB, OP_INC2, OP_DEC2, OP_SWAB, OP_SXT});
`else
  logic unused_mbyte;
  assign unused_mbyte = bus.mbyte;
  assign byte_m       = 1'b0;
`endif

  function automatic logic [15:0] keep_hi(input logic bm, input logic [15:0] dv,
                                          input logic [15:0] w);
    return bm ? {dv[15:8], w[7:0]} : w;
  endfunction

  // One shared adder; subtraction is x + ~y + 1 so carry-out low means borrow.
  always_comb begin
    ax   = d;
    ay   = '0;
    acin = 1'b0;
    case (op)
      OP_ADD:  ay = s;
      OP_SUB:  begin ay = ~s; acin = 1'b1; end
      OP_CMP:  begin ax = s; ay = ~d; acin = 1'b1; end
      OP_ADC:  acin = bus.ci;
      OP_SBC:  begin ay = 16'hFFFF; acin = ~bus.ci; end
      OP_INC2: ay = 16'h0002;
      OP_DEC2: ay = 16'hFFFE;
      OP_INC:  acin = 1'b1;
      OP_DEC:  ay = 16'hFFFF;
      OP_NEG:  begin ax = '0; ay = ~d; acin = 1'b1; end
      default: ;
    endcase
  end

  assign sum17    = {1'b0, ax} + {1'b0, ay} + 17'(acin);
  assign sum9     = {1'b0, ax[7:0]} + {1'b0, ay[7:0]} + 9'(acin);
  assign add_r    = byte_m ? {d[15:8], sum9[7:0]} : sum17[15:0];
  assign add_c    = byte_m ? sum9[8] : sum17[16];
  assign sd       = byte_m ? d[7] : d[15];
  assign ss       = byte_m ? s[7] : s[15];
  assign sa       = byte_m ? add_r[7] : add_r[15];
  assign d_maxpos = byte_m ? (d[7:0] == 8'h7F) : (d == 16'h7FFF);
  assign d_minneg = byte_m ? (d[7:0] == 8'h80) : (d == 16'h8000);
  assign d_ones   = byte_m ? (d[7:0] == 8'hFF) : (d == 16'hFFFF);
  assign d_zero   = byte_m ? (d[7:0] == 8'h00) : (d == 16'h0000);
  assign r_minneg = byte_m ? (add_r[7:0] == 8'h80) : (add_r == 16'h8000);
  assign r_zero   = byte_m ? (add_r[7:0] == 8'h00) : (add_r == 16'h0000);

  always_comb begin
    result_d = '0;
    mask_d   = '0;
    v        = 1'b0;
    c        = 1'b0;
    shift    = 1'b0;
    case (op)
      OP_ADD:  begin result_d = add_r; v = (sd == ss) && (sa != sd); c = add_c;  mask_d = 4'b1111; end
      OP_SUB:  begin result_d = add_r; v = (sd != ss) && (sa == ss); c = ~add_c; mask_d = 4'b1111; end
      OP_CMP:  begin result_d = add_r; v = (ss != sd) && (sa == sd); c = ~add_c; mask_d = 4'b1111; end
      OP_ADC:  begin result_d = add_r; v = d_maxpos & bus.ci; c = d_ones & bus.ci; mask_d = 4'b1111; end
      OP_SBC:  begin result_d = add_r; v = d_minneg; c = d_zero & bus.ci; mask_d = 4'b1111; end
      OP_INC2, OP_DEC2: result_d = add_r;
      OP_INC:  begin result_d = add_r; v = d_maxpos; mask_d = 4'b1110; end
      OP_DEC:  begin result_d = add_r; v = d_minneg; mask_d = 4'b1110; end
      OP_CLR:  begin result_d = keep_hi(byte_m, d, 16'h0000); mask_d = 4'b1111; end
      OP_COM:  begin result_d = keep_hi(byte_m, d, ~d); c = 1'b1; mask_d = 4'b1111; end
      OP_NEG:  begin result_d = add_r; v = r_minneg; c = ~r_zero; mask_d = 4'b1111; end
      OP_TST:  begin result_d = d; mask_d = 4'b1111; end
      OP_ROR:  begin
        result_d = byte_m ? {d[15:8], bus.ci, d[7:1]} : {bus.ci, d[15:1]};
        c = d[0]; shift = 1'b1; mask_d = 4'b1111;
      end
      OP_ROL:  begin
        result_d = byte_m ? {d[15:8], d[6:0], bus.ci} : {d[14:0], bus.ci};
        c = sd; shift = 1'b1; mask_d = 4'b1111;
      end
      OP_ASR:  begin
        result_d = byte_m ? {d[15:8], d[7], d[7:1]} : {d[15], d[15:1]};
        c = d[0]; shift = 1'b1; mask_d = 4'b1111;
      end
      OP_ASL:  begin
        result_d = byte_m ? {d[15:8], d[6:0], 1'b0} : {d[14:0], 1'b0};
        c = sd; shift = 1'b1; mask_d = 4'b1111;
      end
      OP_SXT:  begin result_d = {16{bus.ni}}; mask_d = 4'b0110; end
      OP_MOV:  begin result_d = byte_m ? {{8{s[7]}}, s[7:0]} : s; mask_d = 4'b1110; end
      OP_BIT:  begin result_d = keep_hi(byte_m, d, s & d);  mask_d = 4'b1110; end
      OP_BIC:  begin result_d = keep_hi(byte_m, d, ~s & d); mask_d = 4'b1110; end
      OP_BIS:  begin result_d = keep_hi(byte_m, d, s | d);  mask_d = 4'b1110; end
      OP_EXOR: begin result_d = keep_hi(byte_m, d, s ^ d);  mask_d = 4'b1110; end
      OP_SWAB: begin result_d = {d[7:0], d[15:8]}; mask_d = 4'b1111; end
      default: ;
    endcase
    n = byte_m ? result_d[7] : result_d[15];
    z = byte_m ? (result_d[7:0] == 8'h00) : (result_d == 16'h0000);
    // swab reports on the new low byte; sxt reports on the incoming N.
    if (op == OP_SWAB) begin
      n = result_d[7];
      z = (result_d[7:0] == 8'h00);
    end
    if (op == OP_SXT) begin
      n = bus.ni;
      z = ~bus.ni;
    end
    if (shift) v = n ^ c;
    flags_d = (op == OP_NONE) ? 4'b0000 : {n, z, v, c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.final_result = result_q;
  assign bus.final_flags  = flags_q;
  assign bus.ccmask       = mask_q;
endmodule

// File: tb/tb_myalu_core.sv
// Directed-vector bench for myalu_core; expectations for byte-mode vectors follow MYALU_BYTE_EN.
module tb_myalu_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] strb_tb = '0;
  int n_checks = 0;
  int n_pass = 0;

  myalu_core_if bus_if ();

  assign {bus_if.swab, bus_if.exor, bus_if.bis, bus_if.bic, bus_if.bit_, bus_if.cmp,
          bus_if.mov, bus_if.sxt, bus_if.asl, bus_if.asr, bus_if.rol, bus_if.ror,
          bus_if.tst, bus_if.neg, bus_if.com, bus_if.clr, bus_if.dec, bus_if.inc,
          bus_if.dec2, bus_if.inc2, bus_if.sbc, bus_if.sub, bus_if.adc, bus_if.add} = strb_tb;

  myalu_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] ST_ADD  = 24'h000001, ST_ADC  = 24'h000002, ST_SUB  = 24'h000004;
  localparam logic [23:0] ST_SBC  = 24'h000008, ST_INC2 = 24'h000010, ST_DEC  = 24'h000080;
  localparam logic [23:0] ST_INC  = 24'h000040, ST_CLR  = 24'h000100, ST_COM  = 24'h000200;
  localparam logic [23:0] ST_NEG  = 24'h000400, ST_ROR  = 24'h001000, ST_ROL  = 24'h002000;
  localparam logic [23:0] ST_ASL  = 24'h008000, ST_SXT  = 24'h010000, ST_MOV  = 24'h020000;
  localparam logic [23:0] ST_CMP  = 24'h040000, ST_BIC  = 24'h100000, ST_SWAB = 24'h800000;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %06o expected %06o", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] er, input logic [3:0] ef,
                            input logic [3:0] em);
    check({tag, ".result"}, bus_if.final_result, er);
    check({tag, ".flags"}, {12'h0, bus_if.final_flags}, {12'h0, ef});
    check({tag, ".mask"}, {12'h0, bus_if.ccmask}, {12'h0, em});
  endtask

  task automatic run(input string tag, input logic [23:0] st, input logic [15:0] s,
                     input logic [15:0] d, input logic ni, input logic ci, input logic mb,
                     input logic [15:0] er, input logic [3:0] ef, input logic [3:0] em);
    @(negedge clk);
    strb_tb = st; bus_if.in1 = s; bus_if.in2 = d;
    bus_if.ni = ni; bus_if.ci = ci; bus_if.mbyte = mb;
    @(negedge clk);
    $display("%-8s S=%06o D=%06o -> result %06o flags %04b mask %04b", tag, s, d,
             bus_if.final_result, bus_if.final_flags, bus_if.ccmask);
    check_outs(tag, er, ef, em);
  endtask

  initial begin
    strb_tb = ST_ADD; bus_if.in1 = 16'o1; bus_if.in2 = 16'o1;
    bus_if.ni = 1'b0; bus_if.ci = 1'b0; bus_if.mbyte = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 16'o0, 4'b0000, 4'b0000);
    reset = 1'b0;

    run("add",    ST_ADD,  16'o077777, 16'o000001, 0, 0, 0, 16'o100000, 4'b1010, 4'b1111);
    run("sub",    ST_SUB,  16'o000001, 16'o000000, 0, 0, 0, 16'o177777, 4'b1001, 4'b1111);
    run("swab",   ST_SWAB, 16'o0,      16'o001000, 0, 0, 0, 16'o000002, 4'b0000, 4'b1111);
    run("ror",    ST_ROR,  16'o0,      16'o000001, 0, 1, 0, 16'o100000, 4'b1001, 4'b1111);
    run("none",   24'h0,   16'o7,      16'o7,      0, 0, 0, 16'o0,      4'b0000, 4'b0000);
    run("prio",   ST_ADD | ST_SUB, 16'o1, 16'o2,   0, 0, 0, 16'o3,      4'b0000, 4'b1111);
    run("subovf", ST_SUB,  16'o000001, 16'o100000, 0, 0, 0, 16'o077777, 4'b0010, 4'b1111);
    run("cmp",    ST_CMP,  16'o000000, 16'o000001, 0, 0, 0, 16'o177777, 4'b1001, 4'b1111);
    run("neg",    ST_NEG,  16'o0,      16'o100000, 0, 0, 0, 16'o100000, 4'b1011, 4'b1111);
    run("com",    ST_COM,  16'o0,      16'o000000, 0, 0, 0, 16'o177777, 4'b1001, 4'b1111);
    run("sxt",    ST_SXT,  16'o0,      16'o0,      1, 0, 0, 16'o177777, 4'b1000, 4'b0110);
    run("adc",    ST_ADC,  16'o0,      16'o177777, 0, 1, 0, 16'o000000, 4'b0101, 4'b1111);
    run("sbc",    ST_SBC,  16'o0,      16'o000000, 0, 1, 0, 16'o177777, 4'b1001, 4'b1111);
    run("inc2",   ST_INC2, 16'o0,      16'o177776, 0, 0, 0, 16'o000000, 4'b0100, 4'b0000);
    run("asl",    ST_ASL,  16'o0,      16'o100000, 0, 0, 0, 16'o000000, 4'b0111, 4'b1111);
    run("bic",    ST_BIC,  16'o000017, 16'o000377, 0, 0, 0, 16'o000360, 4'b0000, 4'b1110);
    run("clr",    ST_CLR,  16'o0,      16'o000123, 0, 0, 0, 16'o000000, 4'b0100, 4'b1111);
    run("dec",    ST_DEC,  16'o0,      16'o100000, 0, 0, 0, 16'o077777, 4'b0010, 4'b1110);
    run("addb",   ST_ADD,  16'o000377, 16'o000001, 0, 0, 1, 16'o000400, 4'b0000, 4'b1111);
`ifdef MYALU_BYTE_EN
    run("incb",   ST_INC,  16'o0,      16'o000177, 0, 0, 1, 16'o000200, 4'b1010, 4'b1110);
    run("movb",   ST_MOV,  16'o000200, 16'o0,      0, 0, 1, 16'o177600, 4'b1000, 4'b1110);
    run("rolb",   ST_ROL,  16'o0,      16'o000200, 0, 0, 1, 16'o000000, 4'b0111, 4'b1111);
`else
    run("incb",   ST_INC,  16'o0,      16'o000177, 0, 0, 1, 16'o000200, 4'b0000, 4'b1110);
    run("movb",   ST_MOV,  16'o000200, 16'o0,      0, 0, 1, 16'o000200, 4'b0000, 4'b1110);
    run("rolb",   ST_ROL,  16'o0,      16'o000200, 0, 0, 1, 16'o000400, 4'b0000, 4'b1111);
`endif

    // Reset pulsed while add stays active.
    run("preRst", ST_ADD,  16'o000001, 16'o000001, 0, 0, 0, 16'o000002, 4'b0000, 4'b1111);
    #2 reset = 1'b1;
    #1 check_outs("rstAsync", 16'o0, 4'b0000, 4'b0000);
    @(negedge clk);
    check_outs("rstHold", 16'o0, 4'b0000, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    $display("postRst  result %06o flags %04b mask %04b", bus_if.final_result,
             bus_if.final_flags, bus_if.ccmask);
    check_outs("postRst", 16'o000002, 4'b0000, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
